mem_bus_arbiter: RTL and testbench

- Shares the single block-granular data memory port between the instruction cache and the data cache.
- Each cache presents a cache-controller style miss request (read/write, 6-bit block address, 32-bit block). The arbiter grants one requester at a time, forwards its request to memory and holds the grant until the memory transaction completes.
- Returns the fetched block and a one-cycle busywait release to the owner.
- Sits between both cache controllers and the data memory in the CPU top level.

---
 rtl/mem_bus_arbiter_pkg.sv | 23 ++
 rtl/mem_bus_arbiter_priority.sv | 42 ++++
 rtl/mem_bus_arbiter.sv | 141 ++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// mem_bus_arbiter_pkg
//   Types and constants shared between mem_bus_arbiter, its priority selector
//   and the cache controllers that sit on either side of it.
//   DEF_ADDR_W / DEF_DATA_W : default block address / block data widths.
//   state_t                 : arbiter FSM states (IDLE, GRANT, DONE).
//   owner_t                 : which cache owns the memory port.
package mem_bus_arbiter_pkg;

  localparam int unsigned DEF_ADDR_W = 6;
  localparam int unsigned DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef enum logic {
    OWN_D = 1'b0,
    OWN_I = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_bus_arbiter_priority.sv
// arb_priority_select
//   Combinational winner selection between the data cache and the
//   instruction cache requests.
//   Build option ROUND_ROBIN_EN: when defined, a simultaneous request is
//   granted to the requester that did not own the port last; otherwise the
//   data cache always wins.
//   Ports:
//     d_req      : data cache request (read or write-back)
//     i_req      : instruction cache request
//     last_owner : previous grant owner (only meaningful with ROUND_ROBIN_EN)
//     winner     : selected owner; only meaningful when a request is pending
module arb_priority_select
  import mem_bus_arbiter_pkg::*;
(
  input  logic   d_req,
  input  logic   i_req,
  input  owner_t last_owner,
  output owner_t winner
);

`ifdef ROUND_ROBIN_EN
  always_comb begin
    winner = OWN_D;
    if (d_req && i_req) begin
      winner = (last_owner == OWN_D) ? OWN_I : OWN_D;
    end else if (i_req) begin
      winner = OWN_I;
    end
  end
`else
  logic unused_last_owner;
  assign unused_last_owner = last_owner;

  always_comb begin
    winner = OWN_D;
    if (i_req && !d_req) begin
      winner = OWN_I;
    end
  end
`endif

endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Shares the single block-granular data memory port between the
//   instruction cache and the data cache. One owner at a time; the owner's
//   request is latched on grant, forwarded to memory, and held until memory
//   completes (busywait seen high, then low). The owner is released for
//   exactly one DONE cycle with the fetched block in its readdata register.
//   Build option ROUND_ROBIN_EN: alternate priority on simultaneous requests
//   (default: data cache has fixed priority).
//   Ports:
//     clock, reset                : clock, synchronous active-high reset
//     d_read, d_write             : data cache read / write-back request
//     d_address, d_writedata      : data cache block address / write block
//     d_readdata, d_busywait      : block returned / stall to data cache
//     i_read, i_address           : instruction cache read request / address
//     i_readdata, i_busywait      : block returned / stall to instruction cache
//     mem_read, mem_write         : memory strobes (registered)
//     mem_address, mem_writedata  : memory block address / write block
//     mem_readdata, mem_busywait  : memory read block / busy indication
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [DATA_W-1:0] d_writedata,
  output logic [DATA_W-1:0] d_readdata,
  output logic              d_busywait,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [DATA_W-1:0] i_readdata,
  output logic              i_busywait,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_writedata,
  input  logic [DATA_W-1:0] mem_readdata,
  input  logic              mem_busywait
);

  state_t state;
  owner_t owner;
  owner_t winner;
  logic   seen_busy;
  logic   d_req;
  logic   i_req;

  assign d_req = d_read | d_write;
  assign i_req = i_read;

`ifdef ROUND_ROBIN_EN
  owner_t last_owner;

  arb_priority_select u_select (
    .d_req      (d_req),
    .i_req      (i_req),
    .last_owner (last_owner),
    .winner     (winner)
  );
`else
  arb_priority_select u_select (
    .d_req      (d_req),
    .i_req      (i_req),
    .last_owner (OWN_I),
    .winner     (winner)
  );
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      owner         <= OWN_D;
      seen_busy     <= 1'b0;
      mem_read      <= 1'b0;
      mem_write     <= 1'b0;
      mem_address   <= '0;
      mem_writedata <= '0;
      d_readdata    <= '0;
      i_readdata    <= '0;
`ifdef ROUND_ROBIN_EN
      last_owner    <= OWN_I;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (d_req || i_req) begin
            state     <= GRANT;
            owner     <= winner;
            seen_busy <= 1'b0;
`ifdef ROUND_ROBIN_EN
            last_owner <= winner;
`endif
            if (winner == OWN_D) begin
              // read+write together is a write-back
              mem_read      <= ~d_write;
              mem_write     <= d_write;
              mem_address   <= d_address;
              mem_writedata <= d_writedata;
            end else begin
              mem_read      <= 1'b1;
              mem_write     <= 1'b0;
              mem_address   <= i_address;
              mem_writedata <= '0;
            end
          end
        end
        GRANT: begin
          // complete only once memory has been seen busy, so a memory that
          // is slow to raise busywait is not mistaken for a finished access
          if (seen_busy && !mem_busywait) begin
            state     <= DONE;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            if (owner == OWN_D) begin
              d_readdata <= mem_readdata;
            end else begin
              i_readdata <= mem_readdata;
            end
          end else if (mem_busywait) begin
            seen_busy <= 1'b1;
          end
        end
        DONE: begin
          state     <= IDLE;
          seen_busy <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign d_busywait = !reset && d_req && !(state == DONE && owner == OWN_D);
  assign i_busywait = !reset && i_req && !(state == DONE && owner == OWN_I);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter
//   Randomized and directed stimulus for mem_bus_arbiter, checked every cycle
//   against a transaction-level reference model and a behavioural memory.
module tb_mem_bus_arbiter;
  import mem_bus_arbiter_pkg::*;

  localparam int unsigned AW = DEF_ADDR_W;
  localparam int unsigned DW = DEF_DATA_W;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          d_read = 1'b0;
  logic          d_write = 1'b0;
  logic [AW-1:0] d_address = '0;
  logic [DW-1:0] d_writedata = '0;
  logic [DW-1:0] d_readdata;
  logic          d_busywait;
  logic          i_read = 1'b0;
  logic [AW-1:0] i_address = '0;
  logic [DW-1:0] i_readdata;
  logic          i_busywait;
  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_writedata;
  logic [DW-1:0] mem_readdata = '0;
  logic          mem_busywait = 1'b0;

  always #5 clock = ~clock;

  mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clock         (clock),
    .reset         (reset),
    .d_read        (d_read),
    .d_write       (d_write),
    .d_address     (d_address),
    .d_writedata   (d_writedata),
    .d_readdata    (d_readdata),
    .d_busywait    (d_busywait),
    .i_read        (i_read),
    .i_address     (i_address),
    .i_readdata    (i_readdata),
    .i_busywait    (i_busywait),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_address   (mem_address),
    .mem_writedata (mem_writedata),
    .mem_readdata  (mem_readdata),
    .mem_busywait  (mem_busywait)
  );

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  // reference model: current transfer (0 none, 1 data cache, 2 instr cache)
  int            xfer = 0;
  bit            released = 1'b0;
  bit            saw = 1'b0;
  int            last_own = 2;
  bit            exp_rd = 1'b0;
  bit            exp_wr = 1'b0;
  logic [AW-1:0] exp_addr = '0;
  logic [DW-1:0] exp_wdata = '0;
  logic [DW-1:0] exp_d_rd = '0;
  logic [DW-1:0] exp_i_rd = '0;
  logic [DW-1:0] ref_mem [64];

  // behavioural memory
  logic [DW-1:0] mem_arr [64];
  int            mem_phase = 0;
  int unsigned   mem_pre = 0;
  int unsigned   mem_left = 0;
  logic [AW-1:0] mem_a = '0;
  bit            mem_w = 1'b0;
  logic [DW-1:0] mem_wd = '0;
  int            force_pre = -1;
  int            force_busy = -1;

  // requester behaviour
  bit            auto_req = 1'b0;
  bit            allow_reset = 1'b0;
  int unsigned   d_gap = 0;
  int unsigned   i_gap = 0;
  bit            d_rel = 1'b0;
  bit            i_rel = 1'b0;
  int            rel_order[$];

  function automatic int pick(input bit dq, input bit iq);
    if (dq && iq) begin
`ifdef ROUND_ROBIN_EN
      return (last_own == 1) ? 2 : 1;
`else
      return 1;
`endif
    end
    return dq ? 1 : 2;
  endfunction

  task automatic drive_next();
    bit rst_now;
    bit dq_now;
    bit iq_now;
    bit fin;
    int unsigned op;
    rst_now = reset;
    dq_now  = d_read | d_write;
    iq_now  = i_read;
    d_rel = 1'b0;
    i_rel = 1'b0;
    if (allow_reset) reset = !reset && ($urandom_range(0, 149) == 0);

    if (dq_now && !rst_now && !d_busywait) begin
      d_read = 1'b0; d_write = 1'b0; d_rel = 1'b1;
      rel_order.push_back(1);
      d_gap = $urandom_range(0, 3);
    end else if (dq_now) begin
      if (auto_req && $urandom_range(0, 7) == 0) begin
        d_address = AW'($urandom); d_writedata = $urandom;
      end
    end else if (auto_req) begin
      if (d_gap > 0) d_gap--;
      else begin
        op = $urandom_range(0, 2);
        d_read = (op != 1); d_write = (op != 0);
        d_address = AW'($urandom); d_writedata = $urandom;
      end
    end

    if (iq_now && !rst_now && !i_busywait) begin
      i_read = 1'b0; i_rel = 1'b1;
      rel_order.push_back(2);
      i_gap = $urandom_range(0, 3);
    end else if (iq_now) begin
      if (auto_req && $urandom_range(0, 7) == 0) i_address = AW'($urandom);
    end else if (auto_req) begin
      if (i_gap > 0) i_gap--;
      else begin
        i_read = 1'b1; i_address = AW'($urandom);
      end
    end

    fin = 1'b0;
    if (reset) begin
      mem_phase = 0; mem_busywait = 1'b0;
    end else begin
      if (mem_phase == 2) begin
        mem_busywait = 1'b0;
        if (!(mem_read || mem_write)) mem_phase = 0;
      end else begin
        if (mem_phase == 0 && (mem_read || mem_write)) begin
          mem_phase = 1;
          mem_pre  = (force_pre >= 0) ? unsigned'(force_pre) : $urandom_range(0, 1);
          mem_left = (force_busy >= 0) ? unsigned'(force_busy) : $urandom_range(1, 4);
          mem_a = mem_address; mem_w = mem_write; mem_wd = mem_writedata;
        end
        if (mem_phase == 1) begin
          if (mem_pre > 0) begin
            mem_pre--; mem_busywait = 1'b0;
          end else if (mem_left > 0) begin
            mem_left--; mem_busywait = 1'b1;
          end else begin
            mem_busywait = 1'b0; fin = 1'b1;
            mem_readdata = mem_arr[mem_a];
            if (mem_w) mem_arr[mem_a] = mem_wd;
            mem_phase = 2;
          end
        end else begin
          mem_busywait = 1'b0;
        end
      end
    end
    if (!fin) mem_readdata = $urandom;
  endtask

  task automatic step();
    bit dq, iq, bw, rst, in_xfer;
    dq = d_read | d_write; iq = i_read; bw = mem_busywait; rst = reset;
    @(posedge clock);
    if (rst) begin
      xfer = 0; released = 1'b0; saw = 1'b0; last_own = 2;
      exp_d_rd = '0; exp_i_rd = '0;
    end else if (released) begin
      released = 1'b0; xfer = 0;
    end else if (xfer == 0) begin
      if (dq || iq) begin
        xfer = pick(dq, iq); saw = 1'b0; last_own = xfer;
        if (xfer == 1) begin
          exp_wr = d_write; exp_rd = !d_write; exp_addr = d_address; exp_wdata = d_writedata;
        end else begin
          exp_wr = 1'b0; exp_rd = 1'b1; exp_addr = i_address; exp_wdata = '0;
        end
      end
    end else if (saw && !bw) begin
      released = 1'b1;
      if (exp_rd) check("mem_vs_ref", mem_readdata, ref_mem[exp_addr]);
      if (xfer == 1) exp_d_rd = mem_readdata; else exp_i_rd = mem_readdata;
      if (exp_wr) ref_mem[exp_addr] = exp_wdata;
    end else if (bw) begin
      saw = 1'b1;
    end
    @(negedge clock);
    in_xfer = (xfer != 0) && !released;
    check("mem_read", 32'(mem_read), 32'(in_xfer && exp_rd));
    check("mem_write", 32'(mem_write), 32'(in_xfer && exp_wr));
    if (in_xfer) begin
      check("mem_address", 32'(mem_address), 32'(exp_addr));
      check("mem_writedata", mem_writedata, exp_wdata);
    end
    check("d_busywait", 32'(d_busywait), 32'(!reset && (d_read || d_write) && !(released && xfer == 1)));
    check("i_busywait", 32'(i_busywait), 32'(!reset && i_read && !(released && xfer == 2)));
    check("d_readdata", d_readdata, exp_d_rd);
    check("i_readdata", i_readdata, exp_i_rd);
    drive_next();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit found;
    int exp_first;
    for (int a = 0; a < 64; a++) begin
      mem_arr[a] = $urandom;
      ref_mem[a] = mem_arr[a];
    end

    // reset state
    reset = 1'b1;
    for (int k = 0; k < 3; k++) step();
    check("rst_mem_address", 32'(mem_address), 32'd0);
    check("rst_mem_writedata", mem_writedata, 32'd0);
    reset = 1'b0;
    step();

    // lone data read, 4 busy cycles
    mem_arr[6'h15] = 32'hDEADBEEF; ref_mem[6'h15] = 32'hDEADBEEF;
    force_pre = 0; force_busy = 4;
    d_read = 1'b1; d_address = 6'h15;
    found = 1'b0;
    for (int k = 0; k < 30 && !found; k++) begin
      step();
      if (d_rel) begin
        found = 1'b1;
        check("lone_rdata", d_readdata, 32'hDEADBEEF);
      end
    end
    check("lone_done", 32'(found), 32'd1);
    step();

    // simultaneous write-back and instruction fetch
    rel_order.delete();
    force_busy = 2;
    d_write = 1'b1; d_address = 6'h03; d_writedata = 32'h12345678;
    i_read = 1'b1; i_address = 6'h20;
    for (int k = 0; k < 60 && rel_order.size() < 2; k++) step();
    check("order_count", 32'(rel_order.size()), 32'd2);
`ifdef ROUND_ROBIN_EN
    exp_first = 2;
`else
    exp_first = 1;
`endif
    if (rel_order.size() == 2) check("order_first", 32'(rel_order[0]), 32'(exp_first));
    step();

    // read and write together behave as a write
    d_read = 1'b1; d_write = 1'b1; d_address = 6'h07; d_writedata = 32'hA5A5A5A5;
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      step();
      if (mem_read || mem_write) begin
        found = 1'b1;
        check("rw_mem_write", 32'(mem_write), 32'd1);
        check("rw_mem_read", 32'(mem_read), 32'd0);
      end
    end
    check("rw_granted", 32'(found), 32'd1);
    for (int k = 0; k < 30 && (d_read || d_write); k++) step();

    // memory slow to raise busywait, then read back the earlier write
    force_pre = 1; force_busy = 1;
    d_read = 1'b1; d_address = 6'h03;
    found = 1'b0;
    for (int k = 0; k < 30 && !found; k++) begin
      step();
      if (d_rel) begin
        found = 1'b1;
        check("wr_then_rd", d_readdata, 32'h12345678);
      end
    end
    check("slow_done", 32'(found), 32'd1);
    step();

    // reset two cycles into GRANT, then re-grant from IDLE
    force_pre = 0; force_busy = 4;
    d_read = 1'b1; d_address = 6'h09;
    for (int k = 0; k < 10 && !mem_read; k++) step();
    step();
    reset = 1'b1;
    step();
    check("rst_mid_mem_read", 32'(mem_read), 32'd0);
    check("rst_mid_d_busy", 32'(d_busywait), 32'd0);
    reset = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 30 && !found; k++) begin
      step();
      if (d_rel) found = 1'b1;
    end
    check("rst_regrant", 32'(found), 32'd1);

    // randomized traffic with occasional reset
    force_pre = -1; force_busy = -1;
    auto_req = 1'b1; allow_reset = 1'b1;
    for (int k = 0; k < 3000; k++) step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
